alu_64: RTL and testbench

- 64-bit integer arithmetic/logic unit in the datapath execute stage.
- Takes two 64-bit operands and a 4-bit opcode, and produces a 64-bit result plus a zero flag.
- Result and flags are registered: one-cycle latency, one operation accepted per cycle.
- Operand inputs come from the register-file/immediate muxes; the output feeds writeback and branch-compare logic.

---
 rtl/alu_64_if.sv | 24 ++
 rtl/alu_64.sv | 100 ++++++++++
 tb/tb_alu_64.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_64_if.sv
// Operand/result bundle for alu_64. The carry/overflow/negative flags exist only
// when ALU_FLAGS_EN is defined.
interface alu_64_if #(
  parameter int WIDTH = 64
);
  // No valid/ready: A/B/op are sampled on every rising clk edge, and the result
  // appears on out/zero (and the flags) one cycle later.
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic [WIDTH-1:0] out;
  logic             zero;
`ifdef ALU_FLAGS_EN
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (output A, B, op, input out, zero, carry, overflow, negative);
  modport slave  (input A, B, op, output out, zero, carry, overflow, negative);
`else
  modport master (output A, B, op, input out, zero);
  modport slave  (input A, B, op, output out, zero);
`endif
endinterface

// File: rtl/alu_64.sv
// 64-bit execute-stage ALU with a registered result and zero flag (1-cycle latency).
// Define ALU_FLAGS_EN to add the registered carry/overflow/negative outputs.
module alu_64 #(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_64_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_EQ   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_NOR  = 4'd11,
    OP_PASS = 4'd12
  } op_e;

  logic [WIDTH-1:0] res;
  logic [SHW-1:0]   shamt;

  assign shamt = bus.B[SHW-1:0];

  // Reserved opcodes fall into the default arm and produce 0.
  always_comb begin
    res = '0;
    case (op_e'(bus.op))
      OP_ADD:  res = bus.A + bus.B;
      OP_SUB:  res = bus.A - bus.B;
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
      OP_XOR:  res = bus.A ^ bus.B;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_SLL:  res = bus.A << shamt;
      OP_SRL:  res = bus.A >> shamt;
      OP_SRA:  res = $signed(bus.A) >>> shamt;
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_PASS: res = bus.B;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out  <= '0;
      bus.zero <= 1'b1;
    end else begin
      bus.out  <= res;
      bus.zero <= (res == '0);
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic           carry_d;
  logic           ovf_d;

  // SUB is A + ~B + 1, so the top bit is the not-borrow carry.
  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_w = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    if (bus.op == OP_ADD) begin
      carry_d = add_w[WIDTH];
      ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                (add_w[WIDTH-1] != bus.A[WIDTH-1]);
    end else if (bus.op == OP_SUB) begin
      carry_d = sub_w[WIDTH];
      ovf_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.negative <= 1'b0;
    end else begin
      bus.carry    <= carry_d;
      bus.overflow <= ovf_d;
      bus.negative <= res[WIDTH-1];
    end
  end
`endif
endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed cases plus random ops against a
// reference model; flag outputs are also checked when ALU_FLAGS_EN is defined.
module tb_alu_64;
  logic clk;
  logic rst_n;

  alu_64_if #(.WIDTH(64)) bus ();

  alu_64 #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_q[$];
  logic [2:0]  flag_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // reference model, straight from the opcode table
  function automatic logic [63:0] ref_out(input logic [63:0] a, b, input logic [3:0] o);
    longint sa, sb;
    int sh;
    logic [63:0] r;
    sa = a;
    sb = b;
    sh = int'(b % 64);
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = (a == b) ? 64'd1 : 64'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd7:  r = (a < b) ? 64'd1 : 64'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {a[63], r[63:1]};
      end
      4'd11: r = ~(a | b);
      4'd12: r = b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // {carry, overflow, negative}
  function automatic logic [2:0] ref_flags(input logic [63:0] a, b, input logic [3:0] o);
    logic [64:0] wide;
    logic signed [65:0] s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (o == 4'd0) begin
      wide = {1'b0, a} + {1'b0, b};
      c = wide[64];
      s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
      v = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    end else if (o == 4'd1) begin
      c = (a >= b);
      s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
      v = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    end
    return {c, v, ref_out(a, b, o) >= 64'h8000_0000_0000_0000};
  endfunction

  // driver: apply one op at posedge+1, check it one edge later
  task automatic step(input logic [63:0] a, b, input logic [3:0] o);
    logic [63:0] e;
    logic [2:0]  f;
    bus.A  = a;
    bus.B  = b;
    bus.op = o;
    exp_q.push_back(ref_out(a, b, o));
    flag_q.push_back(ref_flags(a, b, o));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    f = flag_q.pop_front();
    chk($sformatf("op%0d out", o), bus.out, e);
    chk($sformatf("op%0d zero", o), {63'd0, bus.zero}, {63'd0, e == 64'd0});
`ifdef ALU_FLAGS_EN
    chk($sformatf("op%0d flags", o), {61'd0, bus.carry, bus.overflow, bus.negative}, {61'd0, f});
`endif
  endtask

  initial begin
    logic [63:0] a, b;
    logic [3:0]  o;

    rst_n  = 1'b0;
    bus.A  = 64'd5;
    bus.B  = 64'd7;
    bus.op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", bus.out, 64'd0);
    chk("reset zero", {63'd0, bus.zero}, 64'd1);
`ifdef ALU_FLAGS_EN
    chk("reset flags", {61'd0, bus.carry, bus.overflow, bus.negative}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release out", bus.out, 64'd12);
    chk("release zero", {63'd0, bus.zero}, 64'd0);

    // directed cases, back to back
    step(64'd1, 64'd4, 4'd0);
    step(64'd2, '1, 4'd0);
    step(64'd2, 64'd3, 4'd1);
    step(64'd3, 64'd3, 4'd1);
    step(64'd2, 64'd2, 4'd4);
    step(64'd2, 64'd3, 4'd4);
    step(64'h8000_0000_0000_0000, 64'd4, 4'd9);
    step(64'h8000_0000_0000_0000, 64'd4, 4'd10);
    step('1, 64'd1, 4'd6);
    step('1, 64'd1, 4'd7);
    step(64'hDEAD_BEEF_0000_0001, 64'd0, 4'd8);
    step(64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC3, 4'd10);
    step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0);
    step(64'h8000_0000_0000_0000, 64'd1, 4'd1);
    step(64'h1234, 64'h5678, 4'd14);
    step(64'hFFFF, 64'hFFFF, 4'd13);
    step(64'd0, 64'd0, 4'd11);
    step(64'd0, 64'h55, 4'd12);
    step(64'd1, 64'd4, 4'd0);

    // async reset mid-stream discards the in-flight op
    bus.A  = 64'd9;
    bus.B  = 64'd9;
    bus.op = 4'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out", bus.out, 64'd0);
    chk("async rst zero", {63'd0, bus.zero}, 64'd1);
    @(posedge clk);
    #1;
    chk("held rst out", bus.out, 64'd0);
    rst_n = 1'b1;

    // random ops, occasional equal operands
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = b & 64'h3F;
      o = 4'($urandom_range(0, 15));
      step(a, b, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
